simon_decrypt_core: RTL and testbench
=====================================

// Module: simon_decrypt_core
// PURPOSE
//  Iterative SIMON block decryptor. Inverse of the encryption round datapath: applies one inverse round per clock.
//  Takes a 2N-bit ciphertext, reads the expanded round keys in reverse order (ROUNDS-1 down to 0) from an
//  external synchronous key store, and returns the 2N-bit plaintext. Sits beside the encrypt path behind the
//  key schedule's round-key RAM.
// PARAMETERS
//  N       16  word size in bits; only 16, 24, 32, 48, 64 are legal.
//  ROUNDS  32  round count T for the chosen N/key size, e.g. 32 for SIMON32/64.
//  KW      clog2(ROUNDS)  key-address width; derived, not overridden.
// PORTS
//  clk       in   1     single clock, rising edge
//  resetN    in   1     asynchronous, active-low reset
//  inValid   in   1     ciphertext offered
//  inReady   out  1     core can accept a ciphertext
//  inBlock   in   2N    ciphertext {x[2N-1:N], y[N-1:0]}
//  keyAddr   out  KW    round-key read address
//  keyData   in   N     round key; valid one cycle after keyAddr is presented
//  outValid  out  1     plaintext available
//  outReady  in   1     consumer takes plaintext
//  outBlock  out  2N    plaintext {x, y}
//  busy      out  1     high in ROUND or DONE
// BEHAVIOUR
//  - Reset (async, resetN=0): state=IDLE, roundCnt=0, data regs=0, outValid=0, busy=0, inReady=0 while
//    reset is asserted; inReady=1 from the first clock after release.
//  - f(v) = (rotl(v,1) & rotl(v,8)) ^ rotl(v,2).
//    Encrypt round: (x,y) -> (y ^ f(x) ^ k, x).
//    Inverse round: (x,y) -> (y, x ^ f(y) ^ k).
//    All arithmetic is N-bit XOR/AND/rotate; no carries.
//  - FSM states:
//    IDLE: inReady=1, keyAddr=ROUNDS-1. On inValid&&inReady, latch inBlock, set roundCnt=ROUNDS-1, go to ROUND.
//    ROUND: inReady=0. Each cycle apply one inverse round with keyData.
//      keyAddr = roundCnt-1 combinationally, or ROUNDS-1 when roundCnt==0.
//      If roundCnt==0, go to DONE; otherwise decrement roundCnt.
//    DONE: outValid=1 and outBlock holds stable. On outReady, go to IDLE and clear outValid the same edge.
//  - Latency: accept edge E0; rounds applied at E1..E_ROUNDS; outValid high after E_ROUNDS.
//    This gives ROUNDS cycles of latency and a throughput of one block per ROUNDS+2 cycles when outReady is held high.
//  - No overlap: inReady=0 in ROUND and DONE. inValid is ignored there; the upstream holds it.
//  - outBlock=0 except in DONE; it never shows intermediate state.
//  - outReady while not in DONE has no effect. outValid stays high indefinitely if outReady stays low.
//  - keyData is sampled only in ROUND; its value is don't-care elsewhere.
//  - Reset mid-operation aborts immediately, with no partial output.
//  - roundCnt never wraps below 0. keyAddr stays within 0..ROUNDS-1 at all times.
// STRUCTURE
//  - Shared package/include simon_defs: f() function, legal-N check, ROUNDS table per (N, key words), clog2 helper.
//    The encrypt round and the key schedule reuse the same definitions.
//  - One sub-module, simon_inv_round #(N): combinational (x, y, k) -> (x', y').
//  - Top level holds the FSM, the round counter, the 2N-bit state register and the keyAddr mux.
//  - Elaboration error if N is not a legal value.
// TESTING
//  - Known answer, SIMON32/64: key 1918_1110_0908_0100 expanded by a bench model into a 32-entry sync RAM;
//    inBlock=c69b_e9bb -> outBlock=6565_6877 exactly 32 cycles after accept.
//  - Round-trip: 1000 random blocks encrypted by a bench model with a random key, N=16/24/32 builds
//    -> every outBlock equals the original plaintext.
//  - Key-address order: monitor keyAddr during one block -> sequence is 31,30,...,0, each used exactly once
//    in the following cycle.
//  - Backpressure: hold outReady=0 for 50 cycles after outValid -> outValid and outBlock stable, inReady=0,
//    a new inValid is not accepted.
//  - Back-to-back: inValid and outReady held high with 3 blocks -> accepts spaced 34 cycles apart, all outputs correct.
//  - Reset at round 10 (resetN low for 1 cycle) -> outputs zero immediately and inReady=1 after release;
//    the next block decrypts correctly.

Source files
------------

// File: rtl/simon_defs_pkg.sv
// Shared SIMON definitions: round function, legal word sizes, round-count
// table and a clog2 helper. Used by the decrypt core, the encrypt round and
// the key schedule.
package simon_defs_pkg;

    // Widest legal SIMON word; the generic helpers work at this width.
    localparam int MaxN = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } coreState_t;

    // SIMON is only defined for these word sizes.
    function automatic bit isLegalN(input int n);
        return (n == 16) || (n == 24) || (n == 32) || (n == 48) || (n == 64);
    endfunction

    // Round count T for word size n and key-word count m; 0 for an illegal pair.
    function automatic int simonRounds(input int n, input int m);
        int t;
        t = 0;
        case ({n, m})
            {32'd16, 32'd4}: t = 32;
            {32'd24, 32'd3}: t = 36;
            {32'd24, 32'd4}: t = 36;
            {32'd32, 32'd3}: t = 42;
            {32'd32, 32'd4}: t = 44;
            {32'd48, 32'd2}: t = 52;
            {32'd48, 32'd3}: t = 54;
            {32'd64, 32'd2}: t = 68;
            {32'd64, 32'd3}: t = 69;
            {32'd64, 32'd4}: t = 72;
            default:         t = 0;
        endcase
        return t;
    endfunction

    // Address width needed for v entries, never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Rotate the low n bits of v left by s; bits above n come back as zero.
    function automatic logic [MaxN-1:0] rotl(input logic [MaxN-1:0] v,
                                             input int s, input int n);
        logic [MaxN-1:0] mask;
        logic [MaxN-1:0] vm;
        mask = (n >= MaxN) ? '1 : ((MaxN'(1) << n) - MaxN'(1));
        vm   = v & mask;
        return ((vm << s) | (vm >> (n - s))) & mask;
    endfunction

    // SIMON round function f(v) = (v<<<1 & v<<<8) ^ v<<<2 on an n-bit word.
    function automatic logic [MaxN-1:0] simonF(input logic [MaxN-1:0] v,
                                               input int n);
        return (rotl(v, 1, n) & rotl(v, 8, n)) ^ rotl(v, 2, n);
    endfunction

endpackage

// File: rtl/simon_inv_round.sv
// One SIMON inverse round, purely combinational:
// (x, y) -> (y, x ^ f(y) ^ k).
module simon_inv_round
    import simon_defs_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] k,
    output logic [N-1:0] xNext,
    output logic [N-1:0] yNext
);

    // Undo the encrypt round: the old x is now in y, recover old y.
    assign xNext = y;
    assign yNext = x ^ N'(simonF(MaxN'(y), N)) ^ k;

endmodule

// File: rtl/simon_decrypt_core.sv
// Iterative SIMON decryptor: one inverse round per clock, round keys read
// from an external synchronous store in order ROUNDS-1 down to 0.
module simon_decrypt_core
    import simon_defs_pkg::*;
#(
    parameter  int N      = 16,
    parameter  int ROUNDS = 32,
    localparam int KW     = clog2(ROUNDS)
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            inValid,
    output logic            inReady,
    input  logic [2*N-1:0]  inBlock,
    output logic [KW-1:0]   keyAddr,
    input  logic [N-1:0]    keyData,
    output logic            outValid,
    input  logic            outReady,
    output logic [2*N-1:0]  outBlock,
    output logic            busy
);

    if (!isLegalN(N)) begin : gIllegalN
        $error("simon_decrypt_core: N=%0d is not a legal SIMON word size", N);
    end
    if (ROUNDS < 2) begin : gIllegalRounds
        $error("simon_decrypt_core: ROUNDS=%0d is too small", ROUNDS);
    end

    localparam logic [KW-1:0] LastKey = KW'(ROUNDS - 1);

    coreState_t    state;
    coreState_t    nextState;
    logic [KW-1:0] roundCnt;
    logic [N-1:0]  xReg;
    logic [N-1:0]  yReg;
    logic [N-1:0]  xNext;
    logic [N-1:0]  yNext;
    logic          armed;
    logic          accept;

    simon_inv_round #(.N(N)) uInvRound (
        .x     (xReg),
        .y     (yReg),
        .k     (keyData),
        .xNext (xNext),
        .yNext (yNext)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Hold off inReady until the first clock after reset release.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Next-state logic, handshake outputs and key-address mux.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        nextState = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        busy      = 1'b0;
        keyAddr   = LastKey;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                inReady = armed;
                accept  = inValid && armed;
                if (accept) begin
                    nextState = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                // Pre-fetch the key for the next round; the store answers a cycle later.
                if (roundCnt != '0) begin
                    keyAddr = roundCnt - KW'(1);
                end else begin
                    nextState = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                outValid = 1'b1;
                if (outReady) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Block register and round counter: load on accept, one round per ROUND cycle.
    // NOTE: the data registers are reset too, so an aborted block leaves no
    // residue that a later read could expose.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            xReg     <= '0;
            yReg     <= '0;
            roundCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        xReg     <= inBlock[2*N-1:N];
                        yReg     <= inBlock[N-1:0];
                        roundCnt <= LastKey;
                    end
                end
                ROUND: begin
                    xReg <= xNext;
                    yReg <= yNext;
                    if (roundCnt != '0) begin
                        roundCnt <= roundCnt - KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Only a finished block is ever visible on outBlock.
    assign outBlock = (state == DONE) ? {xReg, yReg} : '0;

endmodule

// File: tb/tb_simon_decrypt_core.sv
// Directed bench for simon_decrypt_core (SIMON32/64 build).
module tb_simon_decrypt_core;

    localparam int N      = 16;
    localparam int ROUNDS = 32;
    localparam int KW     = 5;
    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    logic            clk      = 1'b0;
    logic            resetN   = 1'b0;
    logic            inValid  = 1'b0;
    logic            inReady;
    logic [2*N-1:0]  inBlock  = '0;
    logic [KW-1:0]   keyAddr;
    logic [N-1:0]    keyData;
    logic            outValid;
    logic            outReady = 1'b0;
    logic [2*N-1:0]  outBlock;
    logic            busy;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]  keyRam  [ROUNDS];
    logic [KW-1:0] addrLog [ROUNDS];

    simon_decrypt_core #(.N(N), .ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .inValid  (inValid),
        .inReady  (inReady),
        .inBlock  (inBlock),
        .keyAddr  (keyAddr),
        .keyData  (keyData),
        .outValid (outValid),
        .outReady (outReady),
        .outBlock (outBlock),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Synchronous round-key store.
    always @(posedge clk) keyData <= keyRam[keyAddr];

    function automatic logic [15:0] f16(input logic [15:0] v);
        return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
    endfunction

    // SIMON32/64 key schedule into the key store.
    task automatic expandKey(input logic [63:0] key);
        logic [15:0] k [ROUNDS];
        logic [15:0] tmp;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < ROUNDS; i++) begin
            tmp = {k[i-1][2:0], k[i-1][15:3]} ^ k[i-3];
            tmp = tmp ^ {tmp[0], tmp[15:1]};
            k[i] = ~k[i-4] ^ tmp ^ 16'(Z0[61-(i-4)]) ^ 16'h0003;
        end
        for (int i = 0; i < ROUNDS; i++) keyRam[i] = k[i];
    endtask

    function automatic logic [31:0] encrypt(input logic [31:0] p);
        logic [15:0] x, y, t;
        x = p[31:16];
        y = p[15:0];
        for (int i = 0; i < ROUNDS; i++) begin
            t = x;
            x = y ^ f16(x) ^ keyRam[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic failNow(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timed out waiting for the DUT", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one ciphertext and return just after the accept edge.
    task automatic startBlock(input logic [31:0] c);
        int n = 0;
        while (!inReady && n < 100) begin
            tick();
            n++;
        end
        if (!inReady) failNow("inReady wait");
        inBlock    = c;
        inValid    = 1'b1;
        addrLog[0] = keyAddr;
        tick();
        inValid    = 1'b0;
        addrLog[1] = keyAddr;
    endtask

    // Count edges after accept until outValid, logging key addresses.
    task automatic waitDone(output int lat);
        lat = 0;
        while (!outValid && lat < 100) begin
            tick();
            lat++;
            if (lat <= 30) addrLog[lat+1] = keyAddr;
        end
        if (!outValid) failNow("outValid wait");
    endtask

    task automatic takeOutput();
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        logic [31:0] pts [3];
        logic [31:0] cts [3];
        logic [31:0] got [3];
        int accCyc [3];
        int nAcc, nOut, cyc;
        logic acceptNow;
        logic [31:0] p, c;

        // Reset state while resetN is low.
        #12;
        check("reset inReady", 64'(inReady), 64'd0);
        check("reset outValid", 64'(outValid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset outBlock", 64'(outBlock), 64'd0);
        check("reset keyAddr", 64'(keyAddr), 64'd31);
        resetN = 1'b1;
        tick();
        check("inReady after release", 64'(inReady), 64'd1);
        check("busy after release", 64'(busy), 64'd0);

        // Known answer SIMON32/64 with key-address order.
        expandKey(64'h1918_1110_0908_0100);
        startBlock(32'hc69b_e9bb);
        check("ROUND busy", 64'(busy), 64'd1);
        check("ROUND inReady", 64'(inReady), 64'd0);
        check("ROUND outBlock hidden", 64'(outBlock), 64'd0);
        waitDone(lat);
        check("KAT latency", 64'(lat), 64'd32);
        check("KAT outBlock", 64'(outBlock), 64'h6565_6877);
        for (int i = 0; i < ROUNDS; i++)
            check($sformatf("keyAddr[%0d]", i), 64'(addrLog[i]), 64'(ROUNDS - 1 - i));
        takeOutput();
        check("post-take outValid", 64'(outValid), 64'd0);
        check("post-take outBlock", 64'(outBlock), 64'd0);
        check("post-take inReady", 64'(inReady), 64'd1);

        // Backpressure: outReady low 50 cycles, a new inValid must not be taken.
        startBlock(32'hc69b_e9bb);
        waitDone(lat);
        held    = 32'h6565_6877;
        inBlock = 32'h1234_5678;
        inValid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("stall outValid", 64'(outValid), 64'd1);
            check("stall outBlock", 64'(outBlock), 64'(held));
            check("stall inReady", 64'(inReady), 64'd0);
        end
        inValid = 1'b0;
        takeOutput();
        check("stall release inReady", 64'(inReady), 64'd1);
        check("stall release busy", 64'(busy), 64'd0);

        // Back-to-back with inValid and outReady held high.
        pts[0] = 32'h6565_6877;
        pts[1] = 32'h1234_5678;
        pts[2] = 32'hdead_beef;
        for (int i = 0; i < 3; i++) cts[i] = encrypt(pts[i]);
        nAcc = 0;
        nOut = 0;
        cyc  = 0;
        inBlock  = cts[0];
        inValid  = 1'b1;
        outReady = 1'b1;
        while (nOut < 3 && cyc < 300) begin
            acceptNow = inValid && inReady;
            if (outValid) begin
                got[nOut] = outBlock;
                nOut++;
            end
            tick();
            cyc++;
            if (acceptNow) begin
                accCyc[nAcc] = cyc;
                nAcc++;
                if (nAcc < 3) inBlock = cts[nAcc];
                else inValid = 1'b0;
            end
        end
        outReady = 1'b0;
        inValid  = 1'b0;
        if (nOut < 3 || nAcc < 3) failNow("back-to-back");
        else begin
            check("b2b spacing 0-1", 64'(accCyc[1] - accCyc[0]), 64'd34);
            check("b2b spacing 1-2", 64'(accCyc[2] - accCyc[1]), 64'd34);
            for (int i = 0; i < 3; i++)
                check($sformatf("b2b block %0d", i), 64'(got[i]), 64'(pts[i]));
        end

        // Reset at round 10 aborts, then the next block decrypts correctly.
        tick();
        startBlock(32'hc69b_e9bb);
        for (int i = 0; i < 9; i++) tick();
        resetN = 1'b0;
        #1;
        check("abort outValid", 64'(outValid), 64'd0);
        check("abort outBlock", 64'(outBlock), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort inReady", 64'(inReady), 64'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        tick();
        check("abort release inReady", 64'(inReady), 64'd1);
        startBlock(32'hc69b_e9bb);
        waitDone(lat);
        check("post-abort latency", 64'(lat), 64'd32);
        check("post-abort outBlock", 64'(outBlock), 64'h6565_6877);
        takeOutput();

        // Round trip with a random key.
        expandKey({$urandom, $urandom});
        for (int i = 0; i < 1000; i++) begin
            p = $urandom;
            c = encrypt(p);
            startBlock(c);
            waitDone(lat);
            check($sformatf("round trip %0d", i), 64'(outBlock), 64'(p));
            takeOutput();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
